// File: rtl/rom_arb_pkg.sv
// Shared constants for the two-port ROM arbiter: state encoding, default
// widths and port indices.
package rom_arb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    READ = S_READ,
    CAPT = S_CAPT,
    ACK  = S_ACK
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, and under
// contention the port that was not served last wins.
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic sel
);

  always_comb begin
    valid = req0 | req1;
    sel   = P0;
    if (req0 && req1) begin
      sel = ~last_grant;
    end else if (req1) begin
      sel = P1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM between two req/ack ports. Each read walks
// IDLE -> READ -> CAPT -> ACK, and every output comes straight from a flop.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack1,
  output logic [DW-1:0] data1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          pick_valid;
  logic          pick_sel;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .sel        (pick_sel)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rom_addr_d   = rom_addr_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_sel;
          rom_addr_d = (pick_sel == P1) ? addr1 : addr0;
          state_d    = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // Only the granted port's data/ack move; the other port keeps its value.
        if (grant_q == P1) begin
          data1_d = rom_data;
          ack1_d  = 1'b1;
        end else begin
          data0_d = rom_data;
          ack0_d  = 1'b1;
        end
        last_grant_d = grant_q;
        state_d      = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= P0;
      last_grant_q <= P1;
      rom_addr_q   <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rom_addr_q   <= rom_addr_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign data0    = data0_q;
  assign data1    = data1_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios with cycle-exact expectations,
// then random legal requester traffic against a transaction-level model.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
  logic       ack0, ack1, busy;
  logic [7:0] data0, data1;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] rom_mem [16];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read ROM: data is valid the cycle after the address is sampled.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  rom_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .ack0(ack0), .data0(data0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .data1(data1),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 4'd3; addr1 = 4'd5;
    tick(); tick();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
    checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL reset_data0: got %h expected 00", data0); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL reset_data1: got %h expected 00", data1); end
    checks++; if (rom_addr !== 4'd0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (ack0 !== (c == 3)) begin errors++; $display("FAIL reset_first_ack0 c=%0d: got %b expected %b", c, ack0, (c == 3)); end
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_first_ack1 c=%0d: got %b expected 0", c, ack1); end
      if (c == 3) begin
        checks++; if (data0 !== 8'h55) begin errors++; $display("FAIL reset_first_data0: got %h expected 55", data0); end
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    $display("test_reset done: first grant went to port 0");
  endtask

  task automatic test_single();
    logic [7:0] d1;
    d1 = data1;
    req0 = 1'b1; addr0 = 4'd4;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (busy !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, (c <= 3)); end
      checks++; if (ack0 !== (c == 3)) begin errors++; $display("FAIL single_ack0 c=%0d: got %b expected %b", c, ack0, (c == 3)); end
      checks++; if (ack1 !== 1'b0 || data1 !== d1) begin errors++; $display("FAIL single_port1 c=%0d: got ack1=%b data1=%h expected 0/%h", c, ack1, data1, d1); end
      if (c == 3) begin
        checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL single_data0: got %h expected 11", data0); end
        req0 = 1'b0;
      end
    end
    $display("test_single done: port0 addr 4");
  endtask

  task automatic test_contention();
    apply_reset();
    req0 = 1'b1; addr0 = 4'd0; req1 = 1'b1; addr1 = 4'd10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (ack0 !== (c == 3)) begin errors++; $display("FAIL cont_ack0 c=%0d: got %b expected %b", c, ack0, (c == 3)); end
      checks++; if (ack1 !== (c == 7)) begin errors++; $display("FAIL cont_ack1 c=%0d: got %b expected %b", c, ack1, (c == 7)); end
      checks++; if (busy !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin errors++; $display("FAIL cont_busy c=%0d: got %b", c, busy); end
      if (c == 3) begin
        checks++; if (data0 !== 8'hAA) begin errors++; $display("FAIL cont_data0: got %h expected aa", data0); end
        req0 = 1'b0;
      end
      if (c == 7) begin
        checks++; if (data1 !== 8'hFF) begin errors++; $display("FAIL cont_data1: got %h expected ff", data1); end
        req1 = 1'b0;
      end
    end
    $display("test_contention done: port0 then port1");
  endtask

  task automatic test_fairness();
    req0 = 1'b1; addr0 = 4'd1; req1 = 1'b1; addr1 = 4'd9;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++; if (ack0 !== (c == 3 || c == 11)) begin errors++; $display("FAIL fair_ack0 c=%0d: got %b", c, ack0); end
      checks++; if (ack1 !== (c == 7 || c == 15)) begin errors++; $display("FAIL fair_ack1 c=%0d: got %b", c, ack1); end
      if (c == 3 || c == 11) begin
        checks++; if (data0 !== 8'h55) begin errors++; $display("FAIL fair_data0 c=%0d: got %h expected 55", c, data0); end
      end
      if (c == 7 || c == 15) begin
        checks++; if (data1 !== 8'hCC) begin errors++; $display("FAIL fair_data1 c=%0d: got %h expected cc", c, data1); end
      end
      if (c == 15) begin req0 = 1'b0; req1 = 1'b0; end
    end
    $display("test_fairness done: four alternating transactions");
  endtask

  task automatic test_mid_reset();
    req1 = 1'b1; addr1 = 4'd5;
    tick();
    checks++; if (busy !== 1'b1 || rom_addr !== 4'd5) begin errors++; $display("FAIL midrst_read: got busy=%b rom_addr=%h expected 1/5", busy, rom_addr); end
    rst = 1'b0; req1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL midrst_data1: got %h expected 00", data1); end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (ack1 !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet c=%0d: got ack0=%b ack1=%b busy=%b", c, ack0, ack1, busy); end
      tick();
    end
    $display("test_mid_reset done: transaction dropped");
  endtask

  task automatic test_data_hold();
    req1 = 1'b1; addr1 = 4'd1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) begin
        checks++; if (ack1 !== 1'b1 || data1 !== 8'h55) begin errors++; $display("FAIL hold_load1: got ack1=%b data1=%h expected 1/55", ack1, data1); end
        req1 = 1'b0;
      end
    end
    req0 = 1'b1; addr0 = 4'd15;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) addr0 = 4'd7;
      checks++; if (ack1 !== 1'b0 || data1 !== 8'h55) begin errors++; $display("FAIL hold_port1 c=%0d: got ack1=%b data1=%h expected 0/55", c, ack1, data1); end
      checks++; if (ack0 !== (c == 3)) begin errors++; $display("FAIL hold_ack0 c=%0d: got %b expected %b", c, ack0, (c == 3)); end
      if (c == 2) begin
        checks++; if (rom_addr !== 4'd15) begin errors++; $display("FAIL hold_rom_addr: got %h expected f", rom_addr); end
      end
      if (c == 3) begin
        checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL hold_data0: got %h expected 00", data0); end
        req0 = 1'b0;
      end
    end
    $display("test_data_hold done");
  endtask

  // Transaction-level model: when the arbiter is free and someone requests,
  // a grant is made; its ack lands 3 cycles later and the arbiter frees at +4.
  task automatic test_random(input int ncyc);
    int         gcyc;
    logic       gport, last, e_ack0, e_ack1, e_busy;
    logic [7:0] gdata, m0, m1;
    apply_reset();
    gcyc = -10; gport = 1'b0; gdata = 8'h00; last = 1'b1; m0 = 8'h00; m1 = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      e_ack0 = (c == gcyc + 3) && (gport == 1'b0);
      e_ack1 = (c == gcyc + 3) && (gport == 1'b1);
      e_busy = (c > gcyc) && (c <= gcyc + 3);
      if (c == gcyc + 3) begin
        if (gport) m1 = gdata; else m0 = gdata;
        last = gport;
        $display("rand txn c=%0d port=%0d data=%h", c, gport, gdata);
      end
      checks++; if (ack0 !== e_ack0) begin errors++; $display("FAIL rand_ack0 c=%0d: got %b expected %b", c, ack0, e_ack0); end
      checks++; if (ack1 !== e_ack1) begin errors++; $display("FAIL rand_ack1 c=%0d: got %b expected %b", c, ack1, e_ack1); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, e_busy); end
      checks++; if (data0 !== m0) begin errors++; $display("FAIL rand_data0 c=%0d: got %h expected %h", c, data0, m0); end
      checks++; if (data1 !== m1) begin errors++; $display("FAIL rand_data1 c=%0d: got %h expected %h", c, data1, m1); end
      if (e_ack0) req0 = ($urandom_range(3) == 0);
      else if (!req0) req0 = ($urandom_range(2) == 0);
      if (e_ack1) req1 = ($urandom_range(3) == 0);
      else if (!req1) req1 = ($urandom_range(2) == 0);
      addr0 = 4'($urandom_range(15));
      addr1 = 4'($urandom_range(15));
      if (c >= gcyc + 4 && (req0 || req1)) begin
        gport = (req0 && req1) ? ~last : req1;
        gdata = gport ? rom_mem[addr1] : rom_mem[addr0];
        gcyc  = c;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  initial begin
    rom_mem[0]  = 8'hAA; rom_mem[1]  = 8'h55; rom_mem[2]  = 8'hAA; rom_mem[3]  = 8'h55;
    rom_mem[4]  = 8'h11; rom_mem[5]  = 8'h22; rom_mem[6]  = 8'h44; rom_mem[7]  = 8'h88;
    rom_mem[8]  = 8'h99; rom_mem[9]  = 8'hCC; rom_mem[10] = 8'hFF; rom_mem[11] = 8'h08;
    rom_mem[12] = 8'h04; rom_mem[13] = 8'h02; rom_mem[14] = 8'h01; rom_mem[15] = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_mid_reset();
    test_data_hold();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
